// File: rtl/dmac_cfg_if.sv
// APB completer bus bundle for the DMA configuration block.
// Latency: n/a (wiring only).
// Backpressure: the completer stretches the access phase by holding pready low.
//
// Signals:
//   psel, penable, pwrite  requester control
//   paddr, pwdata          requester address / write data (32b)
//   pready, prdata         completer ready / read data (32b)
//   pslverr                completer error response
interface dmac_cfg_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/dmac_cfg.sv
// APB register file holding the DMA source/destination/length and a start command.
// Latency: access completes WAIT_STATES cycles after the first access cycle; start_o one cycle after completion.
// Backpressure: pready held low for WAIT_STATES access cycles; requester must hold the access stable.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   apb             APB completer (dmac_cfg_if.slave)
//   src_addr_o      DMA source address register
//   dst_addr_o      DMA destination address register
//   byte_len_o      DMA transfer length register (16b)
//   start_o         one-cycle start pulse to the DMA engine
//   done_i          engine idle/done (1 = idle)
module dmac_cfg #(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] VERSION     = 32'h0001_2024
) (
  input  logic              clk,
  input  logic              rst,
  dmac_cfg_if.slave         apb,
  output logic [31:0]       src_addr_o,
  output logic [31:0]       dst_addr_o,
  output logic [15:0]       byte_len_o,
  output logic              start_o,
  input  logic              done_i
);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  localparam logic [11:0] A_VERSION = 12'h000;
  localparam logic [11:0] A_SRC     = 12'h100;
  localparam logic [11:0] A_DST     = 12'h104;
  localparam logic [11:0] A_LEN     = 12'h108;
  localparam logic [11:0] A_CMD     = 12'h10C;
  localparam logic [11:0] A_STATUS  = 12'h110;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_wait_cnt;
  logic [2:0]  w_wait_cnt_nxt;

  logic [31:0] r_src;
  logic [31:0] r_dst;
  logic [15:0] r_len;
  logic        r_start;

  logic [11:0] w_off;
  logic        w_pready;
  logic [31:0] w_rdata;
  logic        w_err;
  logic        w_wr_en;
  logic        w_unused;

  // Only the low 12 address bits take part in decode.
  assign w_off    = apb.paddr[11:0];
  assign w_unused = ^apb.paddr[31:12];

  // Completion is forced low while in reset so nothing leaks onto the bus.
  assign w_pready = (r_state == S_ACCESS) && apb.psel && apb.penable &&
                    (r_wait_cnt == WS) && !rst;

  // Read mux and error classification for the addressed register.
  always_comb begin
    w_rdata = '0;
    w_err   = 1'b0;
    case (w_off)
      A_VERSION: begin
        w_rdata = VERSION;
        w_err   = apb.pwrite;
      end
      A_SRC:     w_rdata = r_src;
      A_DST:     w_rdata = r_dst;
      A_LEN:     w_rdata = {16'h0000, r_len};
      // A start request while the engine is busy is refused.
      A_CMD:     w_err = !apb.pwrite || (apb.pwdata[0] && !done_i);
      A_STATUS: begin
        w_rdata = {31'h0, done_i};
        w_err   = apb.pwrite;
      end
      default:   w_err = 1'b1;
    endcase
  end

  // Erroring accesses never touch state.
  assign w_wr_en = w_pready && apb.pwrite && !w_err;

  assign apb.pready  = w_pready;
  assign apb.prdata  = (w_pready && !apb.pwrite) ? w_rdata : 32'h0;
  assign apb.pslverr = w_pready && w_err;

  // Access FSM: next state and wait counter.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      S_IDLE: begin
        if (apb.psel && !apb.penable) begin
          w_state_nxt    = S_ACCESS;
          w_wait_cnt_nxt = 3'd0;
        end
      end
      S_ACCESS: begin
        if (!apb.psel || w_pready) begin
          // Completion or requester abort.
          w_state_nxt = S_IDLE;
        end else if (apb.penable) begin
          w_wait_cnt_nxt = r_wait_cnt + 3'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Register file and start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src   <= 32'h0;
      r_dst   <= 32'h0;
      r_len   <= 16'h0;
      r_start <= 1'b0;
    end else begin
      r_start <= w_wr_en && (w_off == A_CMD) && apb.pwdata[0];
      if (w_wr_en && (w_off == A_SRC)) r_src <= apb.pwdata;
      if (w_wr_en && (w_off == A_DST)) r_dst <= apb.pwdata;
      if (w_wr_en && (w_off == A_LEN)) r_len <= apb.pwdata[15:0];
    end
  end

  assign src_addr_o = r_src;
  assign dst_addr_o = r_dst;
  assign byte_len_o = r_len;
  assign start_o    = r_start;

endmodule

// File: doc/dmac_cfg.md
DMAC_CFG -- requirements
Module: dmac_cfg

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 0, number of access-phase cycles with pready low before completion (legal 0..7).
REQ-002 SHALL have parameter VERSION, default 32'h0001_2024, value returned by the VERSION register.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have ports psel, penable, pwrite  input  1 each  APB completer control.
REQ-006 SHALL have ports paddr, pwdata  input  32 each  APB address and write data.
REQ-007 SHALL have port pready  output  1  access completion.
REQ-008 SHALL have port prdata  output  32  read data.
REQ-009 SHALL have port pslverr  output  1  access error.
REQ-010 SHALL have port src_addr_o  output  32  DMA source address register.
REQ-011 SHALL have port dst_addr_o  output  32  DMA destination address register.
REQ-012 SHALL have port byte_len_o  output  16  DMA transfer length register.
REQ-013 SHALL have port start_o  output  1  one-cycle start pulse to the DMA engine.
REQ-014 SHALL have port done_i  input  1  engine idle/done (1 = idle).

Function
REQ-015 SHALL decode registers from paddr[11:0]: 0x000 VERSION (RO), 0x100 SRC_ADDR (RW), 0x104 DST_ADDR (RW), 0x108 LEN (RW, bits[15:0]; upper bits read 0), 0x10C CMD (WO; bit0 = start; reads 0), 0x110 STATUS (RO; bit0 = done_i; other bits read 0).
REQ-016 SHALL implement an FSM with states IDLE, ACCESS: IDLE -> ACCESS when psel=1 and penable=0; ACCESS -> IDLE on the completing cycle, or when psel=0.
REQ-017 SHALL clear the wait counter on entry to ACCESS, and increment it in each ACCESS cycle where psel=1, penable=1 and pready=0.
REQ-018 SHALL drive pready combinationally: 1 when in ACCESS, psel=1, penable=1 and the wait counter equals WAIT_STATES; otherwise 0.
REQ-019 SHALL treat a cycle with psel=1, penable=1 and pready=1 as the completing cycle; register writes commit on the rising edge that ends it.
REQ-020 SHALL drive prdata with the addressed register value when pready=1 and pwrite=0; otherwise 32'h0.
REQ-021 SHALL drive pslverr=1 only in a completing cycle when any of these holds: the address is unmapped; a write targets VERSION or STATUS; a read targets CMD; a CMD write with bit0=1 occurs while done_i=0. Otherwise pslverr SHALL be 0.
REQ-022 SHALL ignore the write data of any access that raises pslverr; no register changes.
REQ-023 SHALL, on a CMD write with pwdata[0]=1 and done_i=1, assert start_o for exactly one cycle, in the cycle after the completing cycle.
REQ-024 SHALL NOT assert start_o for a CMD write with pwdata[0]=0; the access completes without error.
REQ-025 SHALL, if psel drops in ACCESS before completion, abort the access: no write, no start_o, return to IDLE.
REQ-026 SHALL make back-to-back accesses legal: a setup cycle in the cycle after completion enters ACCESS normally.
REQ-027 SHALL ignore the byte-lane width; all writes are full 32-bit.

Reset
REQ-028 SHALL, while rst=1 at a rising edge, set: FSM to IDLE; wait counter to 0; src_addr_o, dst_addr_o, byte_len_o to 0; start_o to 0.
REQ-029 SHALL hold pready, pslverr and prdata at 0 during reset.
REQ-030 SHALL, if rst is asserted mid-access, discard the access with no register update and no start_o.

Verification
REQ-031 SHALL verify, with WAIT_STATES=0: write 0x100 <- 0x8000_1000, then read 0x100 -> pready in the first access cycle, prdata=0x8000_1000, pslverr=0.
REQ-032 SHALL verify, with WAIT_STATES=3: read 0x000 -> pready low for 3 access cycles, high on the 4th, prdata=0x0001_2024.
REQ-033 SHALL verify: write 0x108 <- 0xFFFF_0040 -> byte_len_o=0x0040; read 0x108 -> 0x0000_0040.
REQ-034 SHALL verify: with done_i=1, write 0x10C <- 1 -> start_o high for exactly 1 cycle after completion. With done_i=0, the same write -> pslverr=1 and start_o stays 0.
REQ-035 SHALL verify: write 0x1FC <- 5 -> pslverr=1, no register change. Write 0x110 <- 1 -> pslverr=1. Read 0x110 with done_i=1 -> 0x0000_0001.
REQ-036 SHALL verify: with WAIT_STATES=2, assert rst during the 2nd access cycle of a write to 0x104 <- 0x1234 -> dst_addr_o=0, FSM in IDLE; the next access completes normally.
